gshare_predictor: RTL and testbench
===================================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 9: width of the branch PC input.
REQ-002 SHALL have parameter IDX_W, default 6: table index width, so the table has 2**IDX_W entries (64).
REQ-003 SHALL have parameter CTR_W, default 2: saturating-counter width, legal range 1..4.
REQ-004 SHALL have parameter GHR_W, default 6: global history length, with 1 <= GHR_W <= IDX_W <= PC_W.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pred_valid, input, 1 bit: prediction request.
REQ-008 SHALL have port pred_pc, input, PC_W bits: PC of the branch to predict.
REQ-009 SHALL have port pred_out_valid, output, 1 bit: prediction result valid.
REQ-010 SHALL have port prediction, output, 1 bit: 1 = predicted taken.
REQ-011 SHALL have port pred_idx, output, IDX_W bits: table index used; the consumer returns it on update.
REQ-012 SHALL have port upd_valid, input, 1 bit: resolved-branch update.
REQ-013 SHALL have port upd_idx, input, IDX_W bits: index previously returned on pred_idx.
REQ-014 SHALL have port upd_taken, input, 1 bit: actual outcome.
REQ-015 SHALL have port upd_pred, input, 1 bit: prediction the consumer received for this branch.
REQ-016 SHALL have port stats_clear, input, 1 bit: synchronous clear of the statistics counters.
REQ-017 SHALL have port stat_total, output, 32 bits: number of updates counted.
REQ-018 SHALL have port stat_correct, output, 32 bits: number of updates with upd_pred == upd_taken.

Function
REQ-019 SHALL hold 2**IDX_W counters of CTR_W bits each, plus a GHR_W-bit global history register (GHR).
REQ-020 SHALL compute the index as pred_pc[IDX_W-1:0] XOR the GHR zero-extended to IDX_W bits.
REQ-021 SHALL, for pred_valid sampled high at edge t, drive pred_out_valid=1, prediction = MSB of the selected counter, and pred_idx at t+1 (1-cycle latency, registered); pred_out_valid SHALL be 0 in cycles without a request.
REQ-022 SHALL, on upd_valid, increment counter[upd_idx] if upd_taken and decrement it otherwise, saturating at 2**CTR_W-1 and at 0 (no wrap).
REQ-023 SHALL, on upd_valid, shift the GHR left with upd_taken entering at bit 0, which makes history non-speculative.
REQ-024 SHALL let a same-edge upd_valid and pred_valid see the pre-update counter and the pre-update GHR, i.e. read-before-write with no bypass.
REQ-025 SHALL, on upd_valid, increment stat_total, and also increment stat_correct when upd_pred == upd_taken; both counters SHALL saturate at 32'hFFFFFFFF.
REQ-026 SHALL give stats_clear priority over a same-cycle increment, so both counters read 0 on the next cycle.
REQ-027 SHALL accept one request and one update per cycle, with no backpressure.

Reset
REQ-028 SHALL, while reset=1, asynchronously force every counter to 2**(CTR_W-1)-1 (weakly not-taken; 1 when CTR_W=2), GHR=0, pred_out_valid=0, prediction=0, pred_idx=0, and both statistics counters to 0.
REQ-029 SHALL discard any request pending when reset asserts mid-operation; the first valid output SHALL follow the first request sampled after reset deasserts.

Configuration
REQ-030 SHALL include the GHR and the XOR hashing only when macro GSHARE_HISTORY_EN is defined.
REQ-031 SHALL, without GSHARE_HISTORY_EN, remove the GHR and use index = pred_pc[IDX_W-1:0] (plain bimodal), with all other behaviour unchanged.

Structure
REQ-032 SHALL place the default parameter values, the counter reset-value function and the saturating inc/dec function in package bp_pkg.
REQ-033 SHALL implement the saturating up/down counter as sub-module sat_counter; the table SHALL be a generate array of sat_counter instances.

Verification
REQ-034 Reset, then pred_pc=9'h005 -> next cycle: pred_out_valid=1, prediction=0, pred_idx=6'h05.
REQ-035 Define GSHARE_HISTORY_EN undefined; issue three updates idx=5, taken=1, then predict pc 5 -> prediction=1; after 5 total taken updates the counter holds 3, with no wrap.
REQ-036 GSHARE_HISTORY_EN defined; apply updates taken=1,0,1 (GHR=3'b101) -> pred_pc=9'h00F yields pred_idx=6'h0A.
REQ-037 Same-cycle update idx=5 taken=1 and predict pc 5 from reset state -> prediction=0; a repeat prediction next cycle -> prediction=1.
REQ-038 Ten updates with upd_pred==upd_taken on 7 of them -> stat_total=10, stat_correct=7; stats_clear together with upd_valid -> both 0.
REQ-039 Assert reset for one cycle mid-stream with a request in flight -> pred_out_valid=0 next cycle and all counters back to the weakly not-taken value.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared defaults and counter arithmetic for the branch predictor.
// Counters are carried at the widest legal width and truncated by the user.
package bp_pkg;
  localparam int PC_W_DEF  = 9;
  localparam int IDX_W_DEF = 6;
  localparam int CTR_W_DEF = 2;
  localparam int GHR_W_DEF = 6;
  localparam int CTR_W_MAX = 4;

  typedef logic [CTR_W_MAX-1:0] ctr_t;

  // Weakly not-taken: the value just below the taken threshold.
  function automatic ctr_t ctr_reset_val(input int w);
    return ctr_t'((1 << (w - 1)) - 1);
  endfunction

  function automatic ctr_t ctr_step(input ctr_t v, input logic up, input int w);
    ctr_t top;
    top = ctr_t'((1 << w) - 1);
    if (up) return (v >= top) ? top : v + ctr_t'(1);
    else    return (v == '0) ? '0 : v - ctr_t'(1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// One saturating up/down table entry; resets to the weakly not-taken value.
module sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  output logic [CTR_W-1:0] value
);
  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(ctr_reset_val(CTR_W));

  logic [CTR_W-1:0] nxt;

  always_comb nxt = CTR_W'(ctr_step(ctr_t'(value), up, CTR_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   value <= RST_VAL;
    else if (en) value <= nxt;
  end
endmodule

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch predictor with registered 1-cycle prediction.
// Define GSHARE_HISTORY_EN to add the global history register and XOR hash.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CTR_W = CTR_W_DEF,
  parameter int GHR_W = GHR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_out_valid,
  output logic             prediction,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  input  logic             stats_clear,
  output logic [31:0]      stat_total,
  output logic [31:0]      stat_correct
);
  localparam int NENT = 1 << IDX_W;

  logic [NENT-1:0][CTR_W-1:0] ctr_q;
  logic [NENT-1:0]            upd_sel;
  logic [IDX_W-1:0]           rd_idx;
  logic [CTR_W-1:0]           rd_ctr;

`ifdef GSHARE_HISTORY_EN
  logic [GHR_W-1:0] ghr;

  // History advances only on resolved branches, so it is never speculative.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ghr <= '0;
    else if (upd_valid) ghr <= GHR_W'({ghr, upd_taken});
  end

  assign rd_idx = pred_pc[IDX_W-1:0] ^ IDX_W'(ghr);
`else
  assign rd_idx = pred_pc[IDX_W-1:0];
`endif

  for (genvar i = 0; i < NENT; i++) begin : g_tbl
    assign upd_sel[i] = upd_valid && (upd_idx == IDX_W'(i));
    sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .en    (upd_sel[i]),
      .up    (upd_taken),
      .value (ctr_q[i])
    );
  end

  // Reads the registered table, so a same-edge update is not visible yet.
  assign rd_ctr = ctr_q[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_out_valid <= 1'b0;
      prediction     <= 1'b0;
      pred_idx       <= '0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        prediction <= rd_ctr[CTR_W-1];
        pred_idx   <= rd_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_total   <= '0;
      stat_correct <= '0;
    end else if (stats_clear) begin
      stat_total   <= '0;
      stat_correct <= '0;
    end else if (upd_valid) begin
      if (stat_total != '1) stat_total <= stat_total + 32'd1;
      if ((upd_pred == upd_taken) && (stat_correct != '1))
        stat_correct <= stat_correct + 32'd1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{pred_pc, rd_ctr};
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor; tracks history itself when GSHARE_HISTORY_EN is set.
module tb_gshare_predictor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0;
  logic [8:0]  pred_pc = '0;
  logic        pred_out_valid;
  logic        prediction;
  logic [5:0]  pred_idx;
  logic        upd_valid = 1'b0;
  logic [5:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred = 1'b0;
  logic        stats_clear = 1'b0;
  logic [31:0] stat_total;
  logic [31:0] stat_correct;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] ghr = '0;

  gshare_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_out_valid (pred_out_valid),
    .prediction     (prediction),
    .pred_idx       (pred_idx),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_pred       (upd_pred),
    .stats_clear    (stats_clear),
    .stat_total     (stat_total),
    .stat_correct   (stat_correct)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] hash(input logic [8:0] pc);
`ifdef GSHARE_HISTORY_EN
    return pc[5:0] ^ ghr;
`else
    return pc[5:0];
`endif
  endfunction

  // PC that lands on table entry idx under the current history.
  function automatic logic [8:0] pc_for(input logic [5:0] idx);
`ifdef GSHARE_HISTORY_EN
    return {3'b000, idx ^ ghr};
`else
    return {3'b000, idx};
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1; pred_valid = 1'b0; upd_valid = 1'b0; stats_clear = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ghr = '0;
  endtask

  task automatic upd(input logic [5:0] idx, input logic t, input logic p);
    upd_valid = 1'b1; upd_idx = idx; upd_taken = t; upd_pred = p;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    ghr = {ghr[4:0], t};
  endtask

  task automatic predict(input logic [8:0] pc, output logic v, output logic p, output logic [5:0] idx);
    pred_valid = 1'b1; pred_pc = pc;
    @(posedge clk); #1;
    pred_valid = 1'b0;
    v = pred_out_valid; p = prediction; idx = pred_idx;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp += 5;
    if (pred_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", pred_out_valid); end
    if (prediction !== 1'b0) begin n_bad++; $display("FAIL reset_pred: got %b want 0", prediction); end
    if (pred_idx !== 6'h00) begin n_bad++; $display("FAIL reset_idx: got %h want 00", pred_idx); end
    if (stat_total !== 32'd0) begin n_bad++; $display("FAIL reset_total: got %0d want 0", stat_total); end
    if (stat_correct !== 32'd0) begin n_bad++; $display("FAIL reset_correct: got %0d want 0", stat_correct); end
    reset = 1'b0;
    ghr = '0;
  endtask

  task automatic test_first_predict();
    logic v, p; logic [5:0] idx;
    do_reset();
    predict(9'h005, v, p, idx);
    n_cmp += 3;
    if (v !== 1'b1) begin n_bad++; $display("FAIL first_vld: got %b want 1", v); end
    if (p !== 1'b0) begin n_bad++; $display("FAIL first_pred: got %b want 0", p); end
    if (idx !== 6'h05) begin n_bad++; $display("FAIL first_idx: got %h want 05", idx); end
    @(posedge clk); #1;
    n_cmp++;
    if (pred_out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_vld: got %b want 0", pred_out_valid); end
  endtask

  task automatic test_saturate();
    logic v, p; logic [5:0] idx; logic [5:0] ei;
    do_reset();
    repeat (3) upd(6'h05, 1'b1, 1'b0);
    ei = 6'h05;
    predict(pc_for(6'h05), v, p, idx);
    n_cmp += 2;
    if (p !== 1'b1) begin n_bad++; $display("FAIL sat_pred3: got %b want 1", p); end
    if (idx !== ei) begin n_bad++; $display("FAIL sat_idx: got %h want %h", idx, ei); end
    repeat (2) upd(6'h05, 1'b1, 1'b0);
    // Held at 3: one decrement still predicts taken, the second does not.
    upd(6'h05, 1'b0, 1'b0);
    predict(pc_for(6'h05), v, p, idx);
    n_cmp++;
    if (p !== 1'b1) begin n_bad++; $display("FAIL sat_nowrap_dec1: got %b want 1", p); end
    upd(6'h05, 1'b0, 1'b0);
    predict(pc_for(6'h05), v, p, idx);
    n_cmp++;
    if (p !== 1'b0) begin n_bad++; $display("FAIL sat_nowrap_dec2: got %b want 0", p); end
    repeat (3) upd(6'h05, 1'b0, 1'b0);
    upd(6'h05, 1'b1, 1'b0);
    predict(pc_for(6'h05), v, p, idx);
    n_cmp++;
    if (p !== 1'b0) begin n_bad++; $display("FAIL sat_floor: got %b want 0", p); end
  endtask

  task automatic test_history();
    logic v, p; logic [5:0] idx; logic [5:0] ei;
    do_reset();
    upd(6'h00, 1'b1, 1'b0);
    upd(6'h00, 1'b0, 1'b0);
    upd(6'h00, 1'b1, 1'b0);
`ifdef GSHARE_HISTORY_EN
    ei = 6'h0A;
`else
    ei = 6'h0F;
`endif
    predict(9'h00F, v, p, idx);
    n_cmp += 2;
    if (idx !== ei) begin n_bad++; $display("FAIL hist_idx: got %h want %h", idx, ei); end
    if (idx !== hash(9'h00F)) begin n_bad++; $display("FAIL hist_hash: got %h want %h", idx, hash(9'h00F)); end
  endtask

  task automatic test_same_cycle();
    logic v, p; logic [5:0] idx;
    do_reset();
    upd_valid = 1'b1; upd_idx = 6'h05; upd_taken = 1'b1; upd_pred = 1'b0;
    pred_valid = 1'b1; pred_pc = 9'h005;
    @(posedge clk); #1;
    upd_valid = 1'b0; pred_valid = 1'b0;
    n_cmp += 3;
    if (pred_out_valid !== 1'b1) begin n_bad++; $display("FAIL rbw_vld: got %b want 1", pred_out_valid); end
    if (prediction !== 1'b0) begin n_bad++; $display("FAIL rbw_pred: got %b want 0", prediction); end
    if (pred_idx !== 6'h05) begin n_bad++; $display("FAIL rbw_idx: got %h want 05", pred_idx); end
    ghr = {ghr[4:0], 1'b1};
    predict(pc_for(6'h05), v, p, idx);
    n_cmp++;
    if (p !== 1'b1) begin n_bad++; $display("FAIL rbw_repeat: got %b want 1", p); end
  endtask

  task automatic test_stats();
    logic [9:0] match;
    logic t;
    match = 10'b1110110011;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      t = (i % 2) == 0;
      upd(6'h0A, t, match[i] ? t : ~t);
    end
    n_cmp += 2;
    if (stat_total !== 32'd10) begin n_bad++; $display("FAIL stat_total: got %0d want 10", stat_total); end
    if (stat_correct !== 32'd7) begin n_bad++; $display("FAIL stat_correct: got %0d want 7", stat_correct); end
    stats_clear = 1'b1; upd_valid = 1'b1; upd_idx = 6'h0A; upd_taken = 1'b1; upd_pred = 1'b1;
    @(posedge clk); #1;
    stats_clear = 1'b0; upd_valid = 1'b0;
    ghr = {ghr[4:0], 1'b1};
    n_cmp += 2;
    if (stat_total !== 32'd0) begin n_bad++; $display("FAIL clr_total: got %0d want 0", stat_total); end
    if (stat_correct !== 32'd0) begin n_bad++; $display("FAIL clr_correct: got %0d want 0", stat_correct); end
    upd(6'h0A, 1'b0, 1'b0);
    n_cmp += 2;
    if (stat_total !== 32'd1) begin n_bad++; $display("FAIL post_clr_total: got %0d want 1", stat_total); end
    if (stat_correct !== 32'd1) begin n_bad++; $display("FAIL post_clr_correct: got %0d want 1", stat_correct); end
  endtask

  task automatic test_reset_midstream();
    logic v, p; logic [5:0] idx;
    do_reset();
    repeat (3) upd(6'h05, 1'b1, 1'b1);
    pred_valid = 1'b1; pred_pc = pc_for(6'h05);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (pred_out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_vld: got %b want 0", pred_out_valid); end
    pred_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ghr = '0;
    n_cmp += 3;
    if (pred_out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_vld: got %b want 0", pred_out_valid); end
    if (stat_total !== 32'd0) begin n_bad++; $display("FAIL mid_total: got %0d want 0", stat_total); end
    if (stat_correct !== 32'd0) begin n_bad++; $display("FAIL mid_correct: got %0d want 0", stat_correct); end
    predict(9'h005, v, p, idx);
    n_cmp += 2;
    if (v !== 1'b1) begin n_bad++; $display("FAIL mid_first_vld: got %b want 1", v); end
    if (p !== 1'b0) begin n_bad++; $display("FAIL mid_weak_nt: got %b want 0", p); end
    upd(6'h05, 1'b1, 1'b0);
    predict(pc_for(6'h05), v, p, idx);
    n_cmp++;
    if (p !== 1'b1) begin n_bad++; $display("FAIL mid_weak_val: got %b want 1", p); end
  endtask

  initial begin
    test_reset();
    test_first_predict();
    test_saturate();
    test_history();
    test_same_cycle();
    test_stats();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
